// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, qualifies lock with timeout/retries,
// then releases per-domain resets in ascending order.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned STAGE_GAP      = 64,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   soft_reset,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   fault,
    output logic [2:0]             retry_cnt
);

    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B   = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    logic [2:0]             state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [1:0]             sync_q;
    logic                   locked_s;
    logic                   pll_rst_nx;
    logic [NUM_DOMAINS-1:0] domain_rst_nx;
    logic                   ready_nx;
    logic                   fault_nx;
    logic [2:0]             retry_cnt_nx;
    logic [2:0]             retry_inc;
    logic                   retry_exhausted;

    assign locked_s        = sync_q[1];
    assign retry_inc       = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
    assign retry_exhausted = (retry_inc == 3'(MAX_RETRIES));

    // State, counter, synchroniser and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= S_PLL_RST;
            cnt        <= '0;
            sync_q     <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            fault      <= 1'b0;
            retry_cnt  <= 3'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sync_q     <= {sync_q[0], pll_locked};
            pll_rst    <= pll_rst_nx;
            domain_rst <= domain_rst_nx;
            ready      <= ready_nx;
            fault      <= fault_nx;
            retry_cnt  <= retry_cnt_nx;
        end
    end

    // Next-state and next-output logic; soft_reset overrides everything below it
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt + CNT_W'(1);
        pll_rst_nx    = pll_rst;
        domain_rst_nx = domain_rst;
        ready_nx      = ready;
        fault_nx      = fault;
        retry_cnt_nx  = retry_cnt;

        case (state)
            S_PLL_RST: begin
                pll_rst_nx = 1'b1;
                if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_nx   = S_WAIT_LOCK;
                    cnt_nx     = '0;
                    pll_rst_nx = 1'b0;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nx = S_STABLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_cnt_nx  = retry_inc;
                    cnt_nx        = '0;
                    pll_rst_nx    = 1'b1;
                    domain_rst_nx = '1;
                    if (retry_exhausted) begin
                        state_nx = S_FAULT;
                        fault_nx = 1'b1;
                    end else begin
                        state_nx = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_nx = S_WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
                    state_nx = S_RELEASE;
                    cnt_nx   = '0;
                end
            end
            S_RELEASE, S_RUN: begin
                if (!locked_s) begin
                    retry_cnt_nx  = retry_inc;
                    cnt_nx        = '0;
                    pll_rst_nx    = 1'b1;
                    domain_rst_nx = '1;
                    ready_nx      = 1'b0;
                    if (retry_exhausted) begin
                        state_nx = S_FAULT;
                        fault_nx = 1'b1;
                    end else begin
                        state_nx = S_PLL_RST;
                    end
                end else if (state == S_RUN) begin
                    cnt_nx = '0;
                end else if (domain_rst == '0) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                    ready_nx = 1'b1;
                end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                    // clear lowest set bit
                    domain_rst_nx = domain_rst & (domain_rst - NUM_DOMAINS'(1));
                    cnt_nx        = '0;
                end
            end
            S_FAULT: begin
                cnt_nx        = '0;
                pll_rst_nx    = 1'b1;
                domain_rst_nx = '1;
                ready_nx      = 1'b0;
                fault_nx      = 1'b1;
            end
            default: begin
                state_nx      = S_PLL_RST;
                cnt_nx        = '0;
                pll_rst_nx    = 1'b1;
                domain_rst_nx = '1;
                ready_nx      = 1'b0;
            end
        endcase

        if (soft_reset) begin
            state_nx      = S_PLL_RST;
            cnt_nx        = '0;
            pll_rst_nx    = 1'b1;
            domain_rst_nx = '1;
            ready_nx      = 1'b0;
            fault_nx      = 1'b0;
            retry_cnt_nx  = 3'd0;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       soft_reset;
    logic       pll_rst;
    logic [3:0] domain_rst;
    logic       ready;
    logic       fault;
    logic [2:0] retry_cnt;

    int total;
    int bad;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (100),
        .LOCK_STABLE   (8),
        .NUM_DOMAINS   (4),
        .STAGE_GAP     (4),
        .MAX_RETRIES   (3)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .soft_reset(soft_reset),
        .pll_rst   (pll_rst),
        .domain_rst(domain_rst),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycles until domain_rst equals val (bounded)
    task automatic wait_dom(input logic [3:0] val, output int n);
        n = 0;
        while (domain_rst !== val && n < 200) begin
            @(negedge refclk);
            n++;
        end
    endtask

    // Number of consecutive samples with pll_rst high, starting now
    task automatic count_pll_rst(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 200) begin
            n++;
            @(negedge refclk);
        end
    endtask

    task automatic wait_pll_rst_high(output int n);
        n = 0;
        while (pll_rst !== 1'b1 && n < 300) begin
            @(negedge refclk);
            n++;
        end
    endtask

    task automatic wait_ready(input logic val, output int n);
        n = 0;
        while (ready !== val && n < 200) begin
            @(negedge refclk);
            n++;
        end
    endtask

    // Domain release staircase followed by ready
    task automatic release_tail(input string tag, input int first);
        int n;
        wait_dom(4'b1110, n);
        chk({tag, " first release"}, n, first);
        wait_dom(4'b1100, n);
        chk({tag, " gap 1100"}, n, 4);
        wait_dom(4'b1000, n);
        chk({tag, " gap 1000"}, n, 4);
        wait_dom(4'b0000, n);
        chk({tag, " gap 0000"}, n, 4);
        wait_ready(1'b1, n);
        chk({tag, " ready delay"}, n, 1);
        chk({tag, " ready pll_rst"}, pll_rst, 0);
    endtask

    task automatic soft_pulse(input string tag);
        soft_reset = 1'b1;
        @(negedge refclk);
        soft_reset = 1'b0;
        chk({tag, " soft fault"}, fault, 0);
        chk({tag, " soft retry"}, retry_cnt, 0);
        chk({tag, " soft domain"}, domain_rst, 4'b1111);
        chk({tag, " soft ready"}, ready, 0);
        chk({tag, " soft pll_rst"}, pll_rst, 1);
    endtask

    initial begin
        int n;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        soft_reset = 1'b0;
        repeat (3) @(negedge refclk);
        chk("reset pll_rst", pll_rst, 1);
        chk("reset domain", domain_rst, 4'b1111);
        chk("reset ready", ready, 0);
        chk("reset fault", fault, 0);
        chk("reset retry", retry_cnt, 0);

        // 1: normal bring-up, lock 10 cycles after pll_rst falls
        rst = 1'b0;
        count_pll_rst(n);
        chk("t1 pll_rst width", n, 4);
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        release_tail("t1", 15);
        chk("t1 retry", retry_cnt, 0);

        // 4: lock loss in RUN
        pll_locked = 1'b0;
        wait_ready(1'b0, n);
        chk("t4 loss latency", n, 3);
        chk("t4 domain", domain_rst, 4'b1111);
        chk("t4 retry", retry_cnt, 1);
        chk("t4 pll_rst", pll_rst, 1);
        pll_locked = 1'b1;
        count_pll_rst(n);
        chk("t4 pll_rst width", n, 4);
        release_tail("t4", 13);
        chk("t4 retry after", retry_cnt, 1);

        // 2: glitch during STABLE restarts the stable count
        soft_pulse("t2");
        count_pll_rst(n);
        chk("t2 pll_rst width", n, 4);
        repeat (6) @(negedge refclk);
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        chk("t2 held domain", domain_rst, 4'b1111);
        pll_locked = 1'b1;
        release_tail("t2", 15);
        chk("t2 retry", retry_cnt, 0);

        // 3: no lock -> three timeouts -> FAULT
        pll_locked = 1'b0;
        soft_pulse("t3");
        count_pll_rst(n);
        chk("t3 pll_rst width", n, 4);
        for (int i = 0; i < 3; i++) begin
            wait_pll_rst_high(n);
            chk($sformatf("t3 timeout %0d", i), n, 100);
            chk($sformatf("t3 retry %0d", i), retry_cnt, i + 1);
            if (i < 2) begin
                chk($sformatf("t3 no fault %0d", i), fault, 0);
                count_pll_rst(n);
                chk($sformatf("t3 pulse %0d", i), n, 4);
            end
        end
        chk("t3 fault", fault, 1);
        chk("t3 domain", domain_rst, 4'b1111);
        chk("t3 pll_rst", pll_rst, 1);
        pll_locked = 1'b1;
        repeat (20) @(negedge refclk);
        chk("t3 fault held", fault, 1);
        chk("t3 pll_rst held", pll_rst, 1);
        chk("t3 ready held", ready, 0);
        chk("t3 retry held", retry_cnt, 3);

        // 5: soft_reset out of FAULT
        soft_pulse("t5");
        count_pll_rst(n);
        chk("t5 pll_rst width", n, 4);
        release_tail("t5", 13);
        chk("t5 retry", retry_cnt, 0);

        // 6: async rst mid-RELEASE
        soft_pulse("t6");
        count_pll_rst(n);
        chk("t6 pll_rst width", n, 4);
        wait_dom(4'b1110, n);
        chk("t6 first release", n, 13);
        wait_dom(4'b1100, n);
        chk("t6 gap 1100", n, 4);
        #2 rst = 1'b1;
        #1;
        chk("t6 async pll_rst", pll_rst, 1);
        chk("t6 async domain", domain_rst, 4'b1111);
        chk("t6 async ready", ready, 0);
        chk("t6 async fault", fault, 0);
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        count_pll_rst(n);
        chk("t6 pll_rst width after", n, 4);
        release_tail("t6", 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
